float_conv_pipe: RTL and testbench

- Parametrised, pipelined successor to the ADPCM FLOATA/FLOATB converters. Converts a signed input sample into the G.726 floating format: {sign, exponent, mantissa}.
- Mode is selected per transaction:
  - mode 0: sign-magnitude input (DQ path).
  - mode 1: two's-complement input (SR path).
- Single instance serves several predictor taps / channels time-multiplexed. A channel tag travels with each sample.
- 3-stage pipeline with valid/ready back-pressure. Sits between the quantizer/reconstruct stage and the FMULT tap multipliers.

---
 rtl/float_pkg.sv | 40 ++++
 rtl/float_prienc.sv | 35 +++
 rtl/float_conv_pipe.sv | 111 +++++++++++
 tb/tb_float_conv_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the G.726 floating-format converter and its consumers.
// Result word layout: {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}.
package float_pkg;

  localparam int FP_MAG_W  = 15;
  localparam int FP_MANT_W = 6;
  localparam int FP_TAG_W  = 3;

  function automatic int float_exp_w(input int mag_w);
    return $clog2(mag_w + 1);
  endfunction

  function automatic int float_out_w(input int mag_w, input int mant_w);
    return 1 + float_exp_w(mag_w) + mant_w;
  endfunction

  function automatic int float_sign_pos(input int mag_w, input int mant_w);
    return float_exp_w(mag_w) + mant_w;
  endfunction

  function automatic int float_exp_lsb(input int mant_w);
    return mant_w;
  endfunction

  // Helpers take the packed word zero-extended to 32 bits so FMULT can reuse them.
  function automatic logic float_get_sign(input logic [31:0] word, input int mag_w,
                                          input int mant_w);
    return word[float_sign_pos(mag_w, mant_w)];
  endfunction

  function automatic logic [31:0] float_get_exp(input logic [31:0] word, input int mag_w,
                                                input int mant_w);
    return (word >> float_exp_lsb(mant_w)) & ((32'(1) << float_exp_w(mag_w)) - 32'(1));
  endfunction

  function automatic logic [31:0] float_get_mant(input logic [31:0] word, input int mant_w);
    return word & ((32'(1) << mant_w) - 32'(1));
  endfunction

endpackage

// File: rtl/float_prienc.sv
// Highest-set-bit encoder: returns (index of top set bit) + 1, or 0 for an all-zero vector.
module float_prienc #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  i_vec,
  output logic [OUT_W-1:0] o_enc
);

  logic [IN_W-1:0] w_above;
  logic [IN_W-1:0] w_first;

  assign w_above[IN_W-1] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < IN_W - 1; gi++) begin : g_above
      assign w_above[gi] = |i_vec[IN_W-1:gi+1];
    end
    // One-hot marker of the most significant set bit.
    for (gi = 0; gi < IN_W; gi++) begin : g_first
      assign w_first[gi] = i_vec[gi] & ~w_above[gi];
    end
  endgenerate

  always_comb begin
    o_enc = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (w_first[i]) begin
        o_enc = o_enc | OUT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/float_conv_pipe.sv
// Three-stage converter from sign-magnitude / two's-complement samples to the G.726
// floating format, with rigid valid/ready back-pressure and a per-sample channel tag.
module float_conv_pipe
  import float_pkg::*;
#(
  parameter  int MAG_W  = FP_MAG_W,
  parameter  int MANT_W = FP_MANT_W,
  parameter  int TAG_W  = FP_TAG_W,
  localparam int EXP_W  = float_exp_w(MAG_W),
  localparam int OUT_W  = float_out_w(MAG_W, MANT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  logic             w_adv;
  logic             w_sign;
  logic [MAG_W-1:0] w_mag;
  logic [EXP_W-1:0] w_exp;
  logic [MANT_W-1:0] w_mant;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [MAG_W-1:0]  r_s1_mag;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [MAG_W-1:0]  r_s2_mag;
  logic [EXP_W-1:0]  r_s2_exp;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              r_s3_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_zero;

  assign w_adv    = !r_s3_valid | out_ready;
  assign in_ready = w_adv;

  // Stage 1: mode is consumed here; negation modulo 2^MAG_W maps the most
  // negative two's-complement input onto mag = 0 with sign still set.
  assign w_sign = in_data[MAG_W];
  assign w_mag  = (in_mode && w_sign) ? (~in_data[MAG_W-1:0] + MAG_W'(1))
                                      : in_data[MAG_W-1:0];

  float_prienc #(
    .IN_W  (MAG_W),
    .OUT_W (EXP_W)
  ) u_prienc (
    .i_vec (r_s1_mag),
    .o_enc (w_exp)
  );

  // mag < 2^exp, so the shifted value always fits in MANT_W bits with MSB set.
  assign w_mant = (r_s2_exp == '0) ? (MANT_W'(1) << (MANT_W - 1))
                                   : MANT_W'({r_s2_mag, {MANT_W{1'b0}}} >> r_s2_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_exp   <= '0;
      r_s2_tag   <= '0;
      r_s3_valid <= 1'b0;
      r_out_data <= '0;
      r_out_tag  <= '0;
      r_out_zero <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_sign;
      r_s1_mag   <= w_mag;
      r_s1_tag   <= in_tag;

      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_mag   <= r_s1_mag;
      r_s2_exp   <= w_exp;
      r_s2_tag   <= r_s1_tag;

      r_s3_valid <= r_s2_valid;
      // Bubbles leave the last result visible rather than loading junk.
      if (r_s2_valid) begin
        r_out_data <= {r_s2_sign, r_s2_exp, w_mant};
        r_out_tag  <= r_s2_tag;
        r_out_zero <= (r_s2_exp == '0);
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_float_conv_pipe.sv
// Directed bench for float_conv_pipe: single conversions, streaming, stall and reset flush.
module tb_float_conv_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_mode;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [2:0]  out_tag;
  logic        out_zero;

  int tests = 0;
  int fails = 0;

  logic [15:0] s_data [8];
  logic        s_mode [8];
  logic [10:0] s_res  [8];

  float_conv_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, req);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic m, input logic [2:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
  endtask

  task automatic single(input string name, input logic [15:0] d, input logic m,
                        input logic [2:0] t, input logic [10:0] res, input logic zero);
    drive(d, m, t);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({name, " lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({name, " lat2"}, 32'(out_valid), 32'd0);
    tick();
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " data"}, 32'(out_data), 32'(res));
    check({name, " tag"}, 32'(out_tag), 32'(t));
    check({name, " zero"}, 32'(out_zero), 32'(zero));
    $display("[TB] %s data=0x%04h mode=%0d -> out=0x%03h tag=%0d zero=%0d",
             name, d, m, out_data, out_tag, out_zero);
    tick();
  endtask

  initial begin
    s_data[0] = 16'h0001; s_mode[0] = 1'b0; s_res[0] = 11'h060;
    s_data[1] = 16'h0002; s_mode[1] = 1'b0; s_res[1] = 11'h0A0;
    s_data[2] = 16'h0003; s_mode[2] = 1'b0; s_res[2] = 11'h0B0;
    s_data[3] = 16'hFFFC; s_mode[3] = 1'b1; s_res[3] = 11'h4E0;
    s_data[4] = 16'h0005; s_mode[4] = 1'b0; s_res[4] = 11'h0E8;
    s_data[5] = 16'h0006; s_mode[5] = 1'b0; s_res[5] = 11'h0F0;
    s_data[6] = 16'h0007; s_mode[6] = 1'b0; s_res[6] = 11'h0F8;
    s_data[7] = 16'h0008; s_mode[7] = 1'b0; s_res[7] = 11'h120;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_tag", 32'(out_tag), 32'd0);
    check("rst out_zero", 32'(out_zero), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    single("m0 0x8005", 16'h8005, 1'b0, 3'd2, 11'h4E8, 1'b0);
    single("m1 0xFFFB", 16'hFFFB, 1'b1, 3'd5, 11'h4E8, 1'b0);
    single("m1 0x8000", 16'h8000, 1'b1, 3'd1, 11'h420, 1'b1);
    single("m0 0x0000", 16'h0000, 1'b0, 3'd3, 11'h020, 1'b1);
    single("m0 0x7FFF", 16'h7FFF, 1'b0, 3'd7, 11'h3FF, 1'b0);
    single("m0 0x0001", 16'h0001, 1'b0, 3'd0, 11'h060, 1'b0);
    single("m0 0x8000", 16'h8000, 1'b0, 3'd4, 11'h420, 1'b1);
    single("m1 0x0005", 16'h0005, 1'b1, 3'd6, 11'h0E8, 1'b0);

    // Back-to-back stream: results on edges 2..9, consecutive and in order.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(s_data[c], s_mode[c], 3'(c));
      else in_valid = 1'b0;
      tick();
      check($sformatf("stream valid c%0d", c), 32'(out_valid), 32'((c >= 2 && c <= 9) ? 1 : 0));
      if (c >= 2 && c <= 9) begin
        check($sformatf("stream data c%0d", c), 32'(out_data), 32'(s_res[c-2]));
        check($sformatf("stream tag c%0d", c), 32'(out_tag), 32'(c - 2));
        $display("[TB] stream tag=%0d out=0x%03h", out_tag, out_data);
      end
    end

    // Stall with the pipeline full, a fourth sample waiting at the input.
    for (int c = 0; c < 3; c++) begin
      drive(s_data[c], s_mode[c], 3'(c));
      tick();
    end
    drive(s_data[3], s_mode[3], 3'd3);
    out_ready = 1'b0;
    #1;
    check("stall in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall valid c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("stall data c%0d", c), 32'(out_data), 32'(s_res[0]));
      check($sformatf("stall tag c%0d", c), 32'(out_tag), 32'd0);
      check($sformatf("stall in_ready c%0d", c), 32'(in_ready), 32'd0);
    end
    $display("[TB] stall held out=0x%03h tag=%0d", out_data, out_tag);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("drain valid %0d", c), 32'(out_valid), 32'd1);
      check($sformatf("drain data %0d", c), 32'(out_data), 32'(s_res[c]));
      check($sformatf("drain tag %0d", c), 32'(out_tag), 32'(c));
      $display("[TB] drain tag=%0d out=0x%03h", out_tag, out_data);
      tick();
    end
    check("drain empty", 32'(out_valid), 32'd0);

    // Reset with three samples in flight discards them all.
    for (int c = 4; c < 7; c++) begin
      drive(s_data[c], s_mode[c], 3'(c));
      tick();
    end
    in_valid = 1'b0;
    check("pre-reset valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_data", 32'(out_data), 32'd0);
    check("flush out_tag", 32'(out_tag), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("flush stale c%0d", c), 32'(out_valid), 32'd0);
    end
    $display("[TB] reset flush done out_valid=%0d in_ready=%0d", out_valid, in_ready);

    single("post-rst 0x8005", 16'h8005, 1'b0, 3'd2, 11'h4E8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
